// File: rtl/handshake_receiver.sv
// Receive endpoint of a 4-phase req/ack CDC link: synchronises req, captures data, streams it out.
// Latency: req_tx edge to ack_tx edge is SYNC_STAGES+1 clk; the word appears on out_data with the ack rise.
// Backpressure: while the output slot is full the receiver withholds ack_tx, which stalls the transmitter.
//
// Ports:
//   clk, rst_n       destination clock, async active-low reset
//   req_tx, data_tx  async request and the bus the transmitter holds stable while req_tx is high
//   ack_tx           registered acknowledge back to the transmitter
//   out_data/out_valid/out_ready  valid/ready output stream
//   rx_busy          high while in ACK, waiting for the request to drop
//   xfer_count       captured-word counter, wraps silently
module handshake_receiver #(
  parameter int DATA_BITS   = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_BITS    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_tx,
  input  logic [DATA_BITS-1:0] data_tx,
  output logic                 ack_tx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 rx_busy,
  output logic [CNT_BITS-1:0]  xfer_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACK  = 2'b01
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   slot_free;

  // Plain flop chain; req_tx is only ever seen through its last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_tx};
    end
  end

  assign req_s     = sync_q[SYNC_STAGES-1];
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ack_tx     <= 1'b0;
      rx_busy    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      xfer_count <= '0;
    end else begin
      // A consumed word empties the slot; a capture below in the same cycle
      // overrides this so the stream sees no bubble.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          // Level-based capture: data_tx is stable here because the
          // transmitter keeps it until it sees our ack.
          if (req_s && slot_free) begin
            out_data   <= data_tx;
            out_valid  <= 1'b1;
            ack_tx     <= 1'b1;
            rx_busy    <= 1'b1;
            xfer_count <= xfer_count + 1'b1;
            state      <= ACK;
          end
        end
        ACK: begin
          // Returning to IDLE only after req drops guarantees one word per pulse.
          if (!req_s) begin
            ack_tx  <= 1'b0;
            rx_busy <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          ack_tx  <= 1'b0;
          rx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_receiver.sv
module tb_handshake_receiver;

  localparam int DB   = 32;
  localparam int SS   = 2;
  localparam int CB   = 4;   // narrow counter so the wrap is reachable quickly
  localparam int TMO  = 40;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_tx;
  logic [DB-1:0] data_tx;
  logic          ack_tx;
  logic [DB-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          rx_busy;
  logic [CB-1:0] xfer_count;

  int total = 0;
  int bad   = 0;
  logic [DB-1:0] exp_q[$];
  logic [CB-1:0] exp_cnt;

  handshake_receiver #(.DATA_BITS(DB), .SYNC_STAGES(SS), .CNT_BITS(CB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_tx     (req_tx),
    .data_tx    (data_tx),
    .ack_tx     (ack_tx),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rx_busy    (rx_busy),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted stream beat must match the oldest word sent.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stream_unexpected: got word %h, expected no word", out_data);
      end else begin
        logic [DB-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          bad++;
          $display("FAIL stream_data: got %h, expected %h", out_data, e);
        end
      end
    end
  end

  // Inputs change 1 time unit after the rising edge; returns edges waited.
  task automatic wait_ack(input logic lvl, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ack_tx !== lvl && n < TMO);
  endtask

  task automatic send_word(input logic [DB-1:0] d);
    int n;
    data_tx = d;
    req_tx  = 1'b1;
    exp_q.push_back(d);
    exp_cnt = exp_cnt + 1'b1;
    wait_ack(1'b1, n);
    total++;
    if (ack_tx !== 1'b1) begin
      bad++;
      $display("FAIL send_ack_rise: ack_tx=%b after %0d clk, expected 1", ack_tx, n);
    end
    req_tx = 1'b0;
    wait_ack(1'b0, n);
    total++;
    if (ack_tx !== 1'b0) begin
      bad++;
      $display("FAIL send_ack_fall: ack_tx=%b after %0d clk, expected 0", ack_tx, n);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_tx = 1'b0; data_tx = '0; out_ready = 1'b1; exp_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    total += 5;
    if (ack_tx !== 1'b0)       begin bad++; $display("FAIL rst_ack: got %b, expected 0", ack_tx); end
    if (out_valid !== 1'b0)    begin bad++; $display("FAIL rst_valid: got %b, expected 0", out_valid); end
    if (out_data !== '0)       begin bad++; $display("FAIL rst_data: got %h, expected 0", out_data); end
    if (xfer_count !== '0)     begin bad++; $display("FAIL rst_count: got %h, expected 0", xfer_count); end
    if (rx_busy !== 1'b0)      begin bad++; $display("FAIL rst_busy: got %b, expected 0", rx_busy); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_latency;
    int n;
    out_ready = 1'b1;
    data_tx = 32'hA5A5_0001;
    req_tx  = 1'b1;
    exp_q.push_back(32'hA5A5_0001);
    exp_cnt = exp_cnt + 1'b1;
    wait_ack(1'b1, n);
    total += 4;
    if (n != SS + 1)          begin bad++; $display("FAIL t1_rise_latency: got %0d clk, expected %0d", n, SS + 1); end
    if (out_valid !== 1'b1)   begin bad++; $display("FAIL t1_valid: got %b, expected 1", out_valid); end
    if (xfer_count !== exp_cnt) begin bad++; $display("FAIL t1_count: got %h, expected %h", xfer_count, exp_cnt); end
    if (rx_busy !== 1'b1)     begin bad++; $display("FAIL t1_busy: got %b, expected 1", rx_busy); end
    req_tx = 1'b0;
    wait_ack(1'b0, n);
    total += 2;
    if (n != SS + 1)          begin bad++; $display("FAIL t2_fall_latency: got %0d clk, expected %0d", n, SS + 1); end
    if (rx_busy !== 1'b0)     begin bad++; $display("FAIL t2_busy: got %b, expected 0", rx_busy); end
    repeat (6) @(posedge clk);
    #1;
    total += 2;
    if (xfer_count !== exp_cnt) begin bad++; $display("FAIL t2_no_second: count %h, expected %h", xfer_count, exp_cnt); end
    if (exp_q.size() != 0)    begin bad++; $display("FAIL t2_drained: %0d words pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure;
    int n;
    out_ready = 1'b0;
    send_word(32'h1);
    data_tx = 32'h2;
    req_tx  = 1'b1;
    exp_q.push_back(32'h2);
    exp_cnt = exp_cnt + 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total += 3;
    if (ack_tx !== 1'b0)      begin bad++; $display("FAIL t3_ack_held_off: got %b, expected 0", ack_tx); end
    if (out_data !== 32'h1)   begin bad++; $display("FAIL t3_data_held: got %h, expected 00000001", out_data); end
    if (out_valid !== 1'b1)   begin bad++; $display("FAIL t3_valid_held: got %b, expected 1", out_valid); end
    out_ready = 1'b1;
    wait_ack(1'b1, n);
    total += 2;
    if (ack_tx !== 1'b1)      begin bad++; $display("FAIL t3_ack_after_ready: got %b, expected 1", ack_tx); end
    if (xfer_count !== exp_cnt) begin bad++; $display("FAIL t3_count: got %h, expected %h", xfer_count, exp_cnt); end
    req_tx = 1'b0;
    wait_ack(1'b0, n);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int n;
    out_ready = 1'b0;
    send_word(32'hBEEF_0010);
    data_tx = 32'hBEEF_0020;
    req_tx  = 1'b1;
    exp_q.push_back(32'hBEEF_0020);
    exp_cnt = exp_cnt + 1'b1;
    repeat (6) @(posedge clk);
    #1;
    out_ready = 1'b1;
    // The accept of the old word and the capture of the new one share this edge.
    @(posedge clk); #1;
    total += 3;
    if (out_valid !== 1'b1)        begin bad++; $display("FAIL t4_no_bubble: valid %b, expected 1", out_valid); end
    if (out_data !== 32'hBEEF_0020) begin bad++; $display("FAIL t4_new_word: got %h, expected beef0020", out_data); end
    if (ack_tx !== 1'b1)           begin bad++; $display("FAIL t4_ack: got %b, expected 1", ack_tx); end
    req_tx = 1'b0;
    wait_ack(1'b0, n);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_wrap;
    out_ready = 1'b1;
    while (exp_cnt != {CB{1'b1}}) send_word(32'hC000_0000 | 32'(exp_cnt));
    total++;
    if (xfer_count !== {CB{1'b1}}) begin bad++; $display("FAIL t5_all_ones: got %h, expected %h", xfer_count, {CB{1'b1}}); end
    send_word(32'hC0DE_FFFF);
    total++;
    if (xfer_count !== '0)   begin bad++; $display("FAIL t5_wrap: got %h, expected 0", xfer_count); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_ack;
    int n;
    out_ready = 1'b0;
    data_tx = 32'h5EED_0006;
    req_tx  = 1'b1;
    exp_q.push_back(32'h5EED_0006);
    wait_ack(1'b1, n);
    #2;
    rst_n = 1'b0;
    #1;
    total += 3;
    if (ack_tx !== 1'b0)     begin bad++; $display("FAIL t6_async_ack: got %b, expected 0", ack_tx); end
    if (out_valid !== 1'b0)  begin bad++; $display("FAIL t6_async_valid: got %b, expected 0", out_valid); end
    if (rx_busy !== 1'b0)    begin bad++; $display("FAIL t6_async_busy: got %b, expected 0", rx_busy); end
    // The word in flight is discarded by reset and recaptured after release.
    exp_q.delete();
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(32'h5EED_0006);
    exp_cnt = exp_cnt + 1'b1;
    wait_ack(1'b1, n);
    total += 4;
    if (n != SS + 1)           begin bad++; $display("FAIL t6_reack_latency: got %0d clk, expected %0d", n, SS + 1); end
    if (out_data !== 32'h5EED_0006) begin bad++; $display("FAIL t6_recapture: got %h, expected 5eed0006", out_data); end
    if (xfer_count !== exp_cnt) begin bad++; $display("FAIL t6_count: got %h, expected %h", xfer_count, exp_cnt); end
    if (out_valid !== 1'b1)    begin bad++; $display("FAIL t6_valid: got %b, expected 1", out_valid); end
    out_ready = 1'b1;
    req_tx = 1'b0;
    wait_ack(1'b0, n);
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (xfer_count !== exp_cnt) begin bad++; $display("FAIL t6_single: count %h, expected %h", xfer_count, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid_ack();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL final_drain: %0d words never delivered, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
